// File: rtl/instr_encoder_loader_pkg.sv
// Shared encodings for the instruction encoder/loader: immediate formats,
// error codes, FSM states and a signed range helper.
package instr_encoder_loader_pkg;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_J    = 3'd4
    } imm_fmt_e;

    typedef enum logic [2:0] {
        ERR_NONE      = 3'd0,
        ERR_IMM_RANGE = 3'd1,
        ERR_IMM_ALIGN = 3'd2,
        ERR_BAD_FMT   = 3'd3,
        ERR_OVERFLOW  = 3'd4
    } err_code_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2,
        ST_ERR  = 2'd3
    } state_e;

    function automatic logic in_range(input logic signed [31:0] v,
                                      input logic signed [31:0] lo,
                                      input logic signed [31:0] hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/instr_encoder_loader_if.sv
// Decoded-field bundle stream into the encoder/loader (valid/ready).
interface instr_encoder_loader_if;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_fmt;
    logic [6:0]  in_opcode;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;
    logic [31:0] in_imm;
    logic        in_last;

    modport master (
        output in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2,
               in_funct3, in_funct7, in_imm, in_last,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2,
               in_funct3, in_funct7, in_imm, in_last,
        output in_ready
    );
endinterface

// File: rtl/instr_encoder_loader_pack.sv
// Combinational RV32I word packer: inverse of the core's immediate extraction,
// plus immediate range, alignment and format checks.
module instr_encoder_loader_pack
    import instr_encoder_loader_pkg::*;
(
    input  logic [2:0]  fmt,
    input  logic [6:0]  opcode,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [31:0] imm,
    output logic [31:0] word,
    output logic        range_err,
    output logic        align_err,
    output logic        fmt_err
);

    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        word      = '0;
        range_err = 1'b0;
        align_err = 1'b0;
        fmt_err   = 1'b0;
        case (fmt)
            IMM_NONE: word = {funct7, rs2, rs1, funct3, rd, opcode};
            IMM_I: begin
                word      = {imm[11:0], rs1, funct3, rd, opcode};
                range_err = !in_range(imm, -32'sd2048, 32'sd2047);
            end
            IMM_S: begin
                word      = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
                range_err = !in_range(imm, -32'sd2048, 32'sd2047);
            end
            IMM_B: begin
                word      = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
                range_err = !in_range(imm, -32'sd4096, 32'sd4094);
                align_err = imm[0];
            end
            IMM_J: begin
                word      = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
                range_err = !in_range(imm, -32'sd1048576, 32'sd1048574);
                align_err = imm[0];
            end
            default: fmt_err = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_encoder_loader.sv
// Program loader: accepts field bundles, packs them into RV32I words and writes
// them to sequential instruction-memory addresses, stopping on the first error.
module instr_encoder_loader
    import instr_encoder_loader_pkg::*;
#(
    parameter  int DEPTH = 1024,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [31:0]             base_addr,
    instr_encoder_loader_if.slave   bus,
    output logic                    mem_we,
    output logic [31:0]             mem_addr,
    output logic [31:0]             mem_wdata,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic [2:0]              err_code,
    output logic [CW-1:0]           word_count
);

    state_e      state_q, state_d;
    logic [31:0] addr_q;
    logic [31:0] word;
    logic        range_err, align_err, fmt_err;
    err_code_e   code;
    logic        ready, hs, do_start;

    instr_encoder_loader_pack u_pack (
        .fmt       (bus.in_fmt),
        .opcode    (bus.in_opcode),
        .rd        (bus.in_rd),
        .rs1       (bus.in_rs1),
        .rs2       (bus.in_rs2),
        .funct3    (bus.in_funct3),
        .funct7    (bus.in_funct7),
        .imm       (bus.in_imm),
        .word      (word),
        .range_err (range_err),
        .align_err (align_err),
        .fmt_err   (fmt_err)
    );

    // Highest-priority failure wins; overflow outranks any field problem.
    always_comb begin
        code = ERR_NONE;
        if (word_count == CW'(DEPTH)) code = ERR_OVERFLOW;
        else if (fmt_err)             code = ERR_BAD_FMT;
        else if (range_err)           code = ERR_IMM_RANGE;
        else if (align_err)           code = ERR_IMM_ALIGN;
    end

    always_comb begin
        state_d  = state_q;
        ready    = 1'b0;
        hs       = 1'b0;
        do_start = 1'b0;
        case (state_q)
            ST_IDLE, ST_ERR: begin
                if (start) begin
                    do_start = 1'b1;
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                ready = 1'b1;
                hs    = bus.in_valid;
                if (hs) begin
                    if (code != ERR_NONE) state_d = ST_ERR;
                    else if (bus.in_last) state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.in_ready = ready;
    assign busy         = (state_q != ST_IDLE);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q     <= '0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
            err_code   <= '0;
            word_count <= '0;
        end else begin
            mem_we <= 1'b0;
            done   <= 1'b0;
            if (do_start) begin
                err        <= 1'b0;
                err_code   <= '0;
                word_count <= '0;
                addr_q     <= {base_addr[31:2], 2'b00};
            end
            if (hs && code == ERR_NONE) begin
                mem_we     <= 1'b1;
                mem_addr   <= addr_q;
                mem_wdata  <= word;
                done       <= bus.in_last;
                addr_q     <= addr_q + 32'd4;  // wraps modulo 2^32 by design
                word_count <= word_count + CW'(1);
            end
            if (hs && code != ERR_NONE) begin
                err      <= 1'b1;
                err_code <= code;
            end
        end
    end

endmodule
